cpu_run_ctrl: RTL and testbench

Run/step sequencer for the board-level pipelined CPU. Converts debounced key pulses into a single-cycle CPU clock-enable (cpu_ce) on the system clock. Supports four modes: single step, free run at a divided rate, N-instruction burst, and stop on a PC breakpoint or halt. Sits between the key debouncer and the PCPU clock/enable input, and also exposes status for the LEDs and display.

---
 rtl/cpu_dbg_pkg.sv | 19 +
 rtl/ce_divider.sv | 46 ++++
 rtl/cpu_run_ctrl.sv | 173 +++++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_dbg_pkg.sv
// Shared definitions for the CPU run/step debug controller.
// Holds the run-state encoding and the default timing/width constants.
// Imported by cpu_run_ctrl and ce_divider; contains no logic.
package cpu_dbg_pkg;

    // Encoding is visible on the status port (LEDs/display), so keep it fixed.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_BURST = 2'd2,
        ST_BREAK = 2'd3
    } run_state_t;

    localparam int DEF_DIV   = 4;
    localparam int DEF_DIV_W = 24;
    localparam int DEF_PC_W  = 8;
    localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/ce_divider.sv
// Purpose: free-running 0..DIV-1 phase counter that paces RUN/BURST pulses.
// Latency: o_due is combinational; it flags the cycle before the DIV-1 slot.
// Backpressure: none; counts whenever enabled, clear has priority.
//
// Ports:
//   i_clk, i_rst   system clock, async active-low reset
//   i_clr          force the count to 0 on the next edge
//   i_en           advance the count this cycle
//   o_due          a pulse should be registered now so it lands in the DIV-1 slot
module ce_divider
    import cpu_dbg_pkg::*;
#(
    parameter int DIV   = DEF_DIV,
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_due
);

    localparam logic [DIV_W-1:0] LAST   = DIV_W'(DIV - 1);
    // cpu_ce is a registered output, so the decision is taken one cycle
    // ahead of the slot in which the pulse is actually seen.
    localparam logic [DIV_W-1:0] DUE_AT = DIV_W'(DIV - 2);

    logic [DIV_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            if (r_cnt == LAST) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_due = i_en && !i_clr && (r_cnt == DUE_AT);

endmodule

// File: rtl/cpu_run_ctrl.sv
// Purpose: turns debounced run/step/burst/stop key pulses into a one-cycle CPU clock enable.
// Latency: step -> cpu_ce next cycle; run/burst -> first cpu_ce DIV cycles after the request.
// Backpressure: none; requests not applicable in the current state are dropped.
//
// Ports:
//   i_clk, i_rst                 system clock, async active-low reset
//   i_step_req/i_run_req/
//   i_stop_req/i_burst_req       one-cycle key pulses (stop > step > burst > run)
//   i_burst_len                  burst length, sampled with i_burst_req
//   i_bp_en, i_bp_addr, i_pc     PC breakpoint enable/address and current CPU address
//   i_halt_seen                  CPU has decoded a halt (level)
//   o_cpu_ce                     one-cycle clock enable to the CPU
//   o_state                      0=IDLE 1=RUN 2=BURST 3=BREAK
//   o_bp_hit, o_halted           sticky stop reasons
//   o_step_cnt                   number of cpu_ce pulses issued (wrapping)
module cpu_run_ctrl
    import cpu_dbg_pkg::*;
#(
    parameter int DIV   = DEF_DIV,
    parameter int DIV_W = DEF_DIV_W,
    parameter int PC_W  = DEF_PC_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_step_req,
    input  logic             i_run_req,
    input  logic             i_stop_req,
    input  logic             i_burst_req,
    input  logic [7:0]       i_burst_len,
    input  logic             i_bp_en,
    input  logic [PC_W-1:0]  i_bp_addr,
    input  logic [PC_W-1:0]  i_pc,
    input  logic             i_halt_seen,
    output logic             o_cpu_ce,
    output logic [1:0]       o_state,
    output logic             o_bp_hit,
    output logic             o_halted,
    output logic [CNT_W-1:0] o_step_cnt
);

    run_state_t       r_state;
    logic             r_cpu_ce;
    logic             r_bp_hit;
    logic             r_halted;
    logic             r_skip_bp;
    logic [7:0]       r_burst_rem;
    logic [CNT_W-1:0] r_step_cnt;

    run_state_t       w_state_nxt;
    logic             w_pulse;
    logic             w_bp_hit_nxt;
    logic             w_halted_nxt;
    logic             w_skip_bp_nxt;
    logic [7:0]       w_burst_rem_nxt;
    logic             w_div_clr;
    logic             w_div_en;
    logic             w_due;
    logic             w_bp_match;

    assign w_div_en   = (r_state == ST_RUN) || (r_state == ST_BURST);
    assign w_bp_match = i_bp_en && (i_pc == i_bp_addr);

    ce_divider #(
        .DIV   (DIV),
        .DIV_W (DIV_W)
    ) u_ce_divider (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (w_div_clr),
        .i_en  (w_div_en),
        .o_due (w_due)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_pulse         = 1'b0;
        w_bp_hit_nxt    = r_bp_hit;
        w_halted_nxt    = r_halted;
        w_skip_bp_nxt   = r_skip_bp;
        w_burst_rem_nxt = r_burst_rem;
        w_div_clr       = 1'b0;

        unique case (r_state)
            ST_IDLE, ST_BREAK: begin
                if (i_stop_req) begin
                    w_state_nxt = ST_IDLE;
                end else if (i_step_req) begin
                    // A step landing on a pulse still in flight is dropped so
                    // cpu_ce can never be high on two consecutive cycles.
                    if (!r_cpu_ce) begin
                        w_pulse      = 1'b1;
                        w_state_nxt  = ST_IDLE;
                        w_bp_hit_nxt = 1'b0;
                        w_halted_nxt = 1'b0;
                    end
                end else if (i_burst_req) begin
                    if (i_burst_len != 8'd0) begin
                        w_state_nxt     = ST_BURST;
                        w_burst_rem_nxt = i_burst_len;
                        w_div_clr       = 1'b1;
                        w_skip_bp_nxt   = 1'b1;
                        w_bp_hit_nxt    = 1'b0;
                        w_halted_nxt    = 1'b0;
                    end
                end else if (i_run_req) begin
                    w_state_nxt   = ST_RUN;
                    w_div_clr     = 1'b1;
                    w_skip_bp_nxt = 1'b1;
                    w_bp_hit_nxt  = 1'b0;
                    w_halted_nxt  = 1'b0;
                end
            end

            ST_RUN, ST_BURST: begin
                if (i_stop_req) begin
                    w_state_nxt = ST_IDLE;
                end else if (i_halt_seen) begin
                    w_state_nxt  = ST_IDLE;
                    w_halted_nxt = 1'b1;
                end else if (w_due) begin
                    // skip_bp lets a resume step off the breakpoint it stopped on.
                    if (w_bp_match && !r_skip_bp) begin
                        w_state_nxt  = ST_BREAK;
                        w_bp_hit_nxt = 1'b1;
                    end else begin
                        w_pulse       = 1'b1;
                        w_skip_bp_nxt = 1'b0;
                        if (r_state == ST_BURST) begin
                            w_burst_rem_nxt = r_burst_rem - 8'd1;
                            if (r_burst_rem == 8'd1) begin
                                w_state_nxt = ST_IDLE;
                            end
                        end
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state     <= ST_IDLE;
            r_cpu_ce    <= 1'b0;
            r_bp_hit    <= 1'b0;
            r_halted    <= 1'b0;
            r_skip_bp   <= 1'b0;
            r_burst_rem <= 8'd0;
            r_step_cnt  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cpu_ce    <= w_pulse;
            r_bp_hit    <= w_bp_hit_nxt;
            r_halted    <= w_halted_nxt;
            r_skip_bp   <= w_skip_bp_nxt;
            r_burst_rem <= w_burst_rem_nxt;
            if (w_pulse) begin
                r_step_cnt <= r_step_cnt + 1'b1;
            end
        end
    end

    assign o_cpu_ce   = r_cpu_ce;
    assign o_state    = r_state;
    assign o_bp_hit   = r_bp_hit;
    assign o_halted   = r_halted;
    assign o_step_cnt = r_step_cnt;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with a pulse-schedule reference model.
// The model tracks when the next pulse is due as an absolute cycle number.
// Step counter is narrowed to 8 bits so the wrap can be reached quickly.
module tb_cpu_run_ctrl;

    localparam int DIV     = 4;
    localparam int CNT_W   = 8;
    localparam int CNT_MOD = 1 << CNT_W;

    logic             clk;
    logic             rst_n;
    logic             step_req, run_req, stop_req, burst_req;
    logic [7:0]       burst_len;
    logic             bp_en;
    logic [7:0]       bp_addr;
    logic [7:0]       pc;
    logic             halt_seen;
    logic             cpu_ce;
    logic [1:0]       state;
    logic             bp_hit;
    logic             halted;
    logic [CNT_W-1:0] step_cnt;

    cpu_run_ctrl #(
        .DIV   (DIV),
        .DIV_W (24),
        .PC_W  (8),
        .CNT_W (CNT_W)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst_n),
        .i_step_req  (step_req),
        .i_run_req   (run_req),
        .i_stop_req  (stop_req),
        .i_burst_req (burst_req),
        .i_burst_len (burst_len),
        .i_bp_en     (bp_en),
        .i_bp_addr   (bp_addr),
        .i_pc        (pc),
        .i_halt_seen (halt_seen),
        .o_cpu_ce    (cpu_ce),
        .o_state     (state),
        .o_bp_hit    (bp_hit),
        .o_halted    (halted),
        .o_step_cnt  (step_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    bit run_chk = 1'b0;
    bit pc_auto = 1'b0;
    int pulses[$];

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    // mode: 0 idle, 1 run, 2 burst, 3 break. next_pulse is the absolute
    // cycle in which the next free-run pulse should be visible.
    typedef struct packed {
        int   mode;
        logic ce;
        logic bp_hit;
        logic halted;
        int   cnt;
        int   next_pulse;
        int   rem;
        logic skip;
    } mdl_t;

    mdl_t m;

    function automatic mdl_t mdl_next(mdl_t s, int c);
        mdl_t n = s;
        n.ce = 1'b0;
        if (s.mode == 0 || s.mode == 3) begin
            if (stop_req) begin
                n.mode = 0;
            end else if (step_req) begin
                if (!s.ce) begin
                    n.ce = 1'b1; n.cnt = (s.cnt + 1) % CNT_MOD; n.mode = 0;
                    n.bp_hit = 1'b0; n.halted = 1'b0;
                end
            end else if (burst_req) begin
                if (burst_len != 0) begin
                    n.mode = 2; n.rem = int'(burst_len); n.next_pulse = c + DIV;
                    n.skip = 1'b1; n.bp_hit = 1'b0; n.halted = 1'b0;
                end
            end else if (run_req) begin
                n.mode = 1; n.next_pulse = c + DIV;
                n.skip = 1'b1; n.bp_hit = 1'b0; n.halted = 1'b0;
            end
        end else begin
            if (stop_req) begin
                n.mode = 0;
            end else if (halt_seen) begin
                n.mode = 0; n.halted = 1'b1;
            end else if (c + 1 == s.next_pulse) begin
                if (bp_en && pc == bp_addr && !s.skip) begin
                    n.mode = 3; n.bp_hit = 1'b1;
                end else begin
                    n.ce = 1'b1; n.cnt = (s.cnt + 1) % CNT_MOD; n.skip = 1'b0;
                    n.next_pulse = s.next_pulse + DIV;
                    if (s.mode == 2) begin
                        n.rem = s.rem - 1;
                        if (n.rem == 0) n.mode = 0;
                    end
                end
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else        m <= mdl_next(m, cyc);
    end

    // ---------------- checking ----------------
    task automatic chk(string nm, longint act, longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: actual=%0d required=%0d", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (run_chk) begin
            chk("cpu_ce",   cpu_ce,   m.ce);
            chk("state",    state,    m.mode);
            chk("bp_hit",   bp_hit,   m.bp_hit);
            chk("halted",   halted,   m.halted);
            chk("step_cnt", step_cnt, m.cnt);
            if (cpu_ce) pulses.push_back(cyc);
        end
    end

    task automatic check_pulses(string nm, int t0, int n, int first, int per);
        bit ok;
        int first_act;
        ok = (pulses.size() == n);
        for (int k = 0; k < n && ok; k++)
            if (pulses[k] != t0 + first + k * per) ok = 1'b0;
        first_act = (pulses.size() > 0) ? pulses[0] - t0 : -1;
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: actual %0d pulses first at +%0d, required %0d pulses at +%0d every %0d",
                     nm, pulses.size(), first_act, n, first, per);
        end
    endtask

    // ---------------- stimulus ----------------
    task automatic tick();
        bit ce_before;
        ce_before = cpu_ce;
        @(posedge clk);
        #1;
        // The CPU advances its address on the edge that consumes cpu_ce.
        if (pc_auto && ce_before) pc = pc + 8'd1;
    endtask

    task automatic wait_until(int c);
        int g = 0;
        while (cyc < c && g < 1000) begin
            tick();
            g++;
        end
    endtask

    task automatic idle(int n);
        repeat (n) tick();
    endtask

    initial begin
        int t0;
        int guard;
        int k;
        rst_n = 1'b0; step_req = 0; run_req = 0; stop_req = 0; burst_req = 0;
        burst_len = 8'd0; bp_en = 0; bp_addr = 8'd0; pc = 8'd0; halt_seen = 0;

        @(posedge clk); #1;
        run_chk = 1'b1;
        chk("rst_state", state, 0);
        chk("rst_ce", cpu_ce, 0);
        chk("rst_cnt", step_cnt, 0);
        chk("rst_bp", bp_hit, 0);
        chk("rst_halted", halted, 0);
        idle(2);
        rst_n = 1'b1;
        idle(3);

        // single step
        pulses.delete(); t0 = cyc;
        step_req = 1; tick(); step_req = 0;
        idle(4);
        check_pulses("step_pulse", t0, 1, 1, 0);
        chk("step_cnt1", step_cnt, 1);
        chk("step_state", state, 0);

        // free run, stop before the third pulse
        pulses.delete(); t0 = cyc;
        run_req = 1; tick(); run_req = 0;
        wait_until(t0 + 10);
        stop_req = 1; tick(); stop_req = 0;
        wait_until(t0 + 16);
        check_pulses("run_stop", t0, 2, 4, 4);
        chk("run_stop_state", state, 0);
        chk("run_stop_cnt", step_cnt, 3);

        // burst of three
        pulses.delete(); t0 = cyc; burst_len = 8'd3;
        burst_req = 1; tick(); burst_req = 0;
        wait_until(t0 + 16);
        check_pulses("burst3", t0, 3, 4, 4);
        chk("burst3_state", state, 0);
        chk("burst3_cnt", step_cnt, 6);

        // zero-length burst does nothing
        pulses.delete(); t0 = cyc; burst_len = 8'd0;
        burst_req = 1; tick(); burst_req = 0;
        idle(10);
        check_pulses("burst0", t0, 0, 0, 0);
        chk("burst0_state", state, 0);

        // breakpoint at 0x05 while the pc walks 3,4,5
        bp_en = 1; bp_addr = 8'h05; pc = 8'h03; pc_auto = 1;
        pulses.delete(); t0 = cyc;
        run_req = 1; tick(); run_req = 0;
        wait_until(t0 + 13);
        check_pulses("bp_run", t0, 2, 4, 4);
        chk("bp_state", state, 3);
        chk("bp_hit", bp_hit, 1);
        chk("bp_cnt", step_cnt, 8);

        // resume from the breakpoint: first pulse issued with pc still 0x05
        pulses.delete(); t0 = cyc;
        run_req = 1; tick(); run_req = 0;
        wait_until(t0 + 9);
        stop_req = 1; tick(); stop_req = 0;
        idle(4);
        check_pulses("bp_resume", t0, 2, 4, 4);
        chk("bp_resume_hit", bp_hit, 0);
        chk("bp_resume_state", state, 0);
        pc_auto = 0; bp_en = 0;

        // halt during run
        pulses.delete(); t0 = cyc;
        run_req = 1; tick(); run_req = 0;
        wait_until(t0 + 5);
        halt_seen = 1;
        wait_until(t0 + 9);
        check_pulses("halt_run", t0, 1, 4, 0);
        chk("halt_state", state, 0);
        chk("halt_flag", halted, 1);
        chk("halt_cnt", step_cnt, 11);

        // step past the halt
        pulses.delete(); t0 = cyc;
        step_req = 1; tick(); step_req = 0;
        idle(3);
        check_pulses("halt_step", t0, 1, 1, 0);
        chk("halt_step_flag", halted, 0);
        halt_seen = 0;

        // stop beats step
        pulses.delete(); t0 = cyc;
        step_req = 1; stop_req = 1; tick(); step_req = 0; stop_req = 0;
        idle(3);
        check_pulses("stop_vs_step", t0, 0, 0, 0);
        chk("stop_vs_step_cnt", step_cnt, 12);

        // step counter wrap
        guard = 0;
        while (m.cnt != CNT_MOD - 1 && guard < 400) begin
            step_req = 1; tick(); step_req = 0; tick();
            guard++;
        end
        chk("pre_wrap", step_cnt, 255);
        step_req = 1; tick(); step_req = 0; tick();
        chk("wrap", step_cnt, 0);

        // reset while a run pulse is on the wire
        run_req = 1; tick(); run_req = 0;
        k = 0;
        while (!cpu_ce && k < 8) begin
            tick();
            k++;
        end
        chk("rst_wait_ce", cpu_ce, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ce", cpu_ce, 0);
        chk("midrst_state", state, 0);
        chk("midrst_cnt", step_cnt, 0);
        chk("midrst_bp", bp_hit, 0);
        chk("midrst_halted", halted, 0);
        idle(2);
        rst_n = 1'b1;
        pulses.delete(); t0 = cyc;
        idle(8);
        check_pulses("post_rst", t0, 0, 0, 0);
        chk("post_rst_state", state, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
